// File: rtl/tpsram_fifo.sv
// Synchronous FIFO over an inferred two-port RAM with occupancy, threshold and sticky error flags.
// Latency: RD/RD_VALID appear one cycle after an accepted REN; flags track COUNT in the same cycle.
// Backpressure: writes are refused while FULL, reads while EMPTY; refusals raise sticky OVERFLOW/UNDERFLOW.
module tpsram_fifo #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 5,
    parameter int AFULL_THRESH  = 28,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic                  WEN,
    output logic [DATA_WIDTH-1:0] RD,
    input  logic                  REN,
    output logic                  RD_VALID,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  AFULL,
    output logic                  AEMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
    input  logic                  ERR_CLR
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AFULL_C   = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AEMPTY_C  = AEMPTY_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] ONE_C     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance is judged against the registered flags, so a same-cycle read
    // never frees space for a write and a same-cycle write never feeds a read.
    assign wr_acc = WEN & ~FULL;
    assign rd_acc = REN & ~EMPTY;

    // Next occupancy; flags are derived from it so they line up with COUNT.
    always_comb begin
        count_nxt = COUNT;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = COUNT + ONE_C;
            2'b01:   count_nxt = COUNT - ONE_C;
            default: count_nxt = COUNT;
        endcase
    end

    // RAM write port; contents deliberately left unreset.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= WD;
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wptr   <= '0;
            rptr   <= '0;
            COUNT  <= '0;
            FULL   <= 1'b0;
            EMPTY  <= 1'b1;
            AFULL  <= 1'b0;
            AEMPTY <= 1'b1;
        end else begin
            if (wr_acc) wptr <= wptr + ONE_C;
            if (rd_acc) rptr <= rptr + ONE_C;
            COUNT  <= count_nxt;
            FULL   <= (count_nxt == DEPTH_C);
            EMPTY  <= (count_nxt == '0);
            AFULL  <= (count_nxt >= AFULL_C);
            AEMPTY <= (count_nxt <= AEMPTY_C);
        end
    end

    // Registered read port: RD holds its value unless a read is accepted.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RD       <= '0;
            RD_VALID <= 1'b0;
        end else begin
            RD_VALID <= rd_acc;
            if (rd_acc) begin
                RD <= mem[rptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes priority.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (WEN & FULL)   OVERFLOW <= 1'b1;
            else if (ERR_CLR) OVERFLOW <= 1'b0;
            if (REN & EMPTY)  UNDERFLOW <= 1'b1;
            else if (ERR_CLR) UNDERFLOW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tpsram_fifo.sv
// Directed bench for tpsram_fifo at default parameters (16 x 32, thresholds 28/4).
// Inputs change on the falling edge; outputs are sampled on the falling edge after the rising edge.
// Expected values are computed from the stimulus itself.
module tb_tpsram_fifo;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [15:0] WD = '0;
    logic        WEN = 1'b0;
    logic        REN = 1'b0;
    logic        ERR_CLR = 1'b0;
    logic [15:0] RD;
    logic        RD_VALID, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW;
    logic [5:0]  COUNT;

    int passed = 0;
    int total  = 0;

    tpsram_fifo #(
        .DATA_WIDTH(16), .ADDR_WIDTH(5), .AFULL_THRESH(28), .AEMPTY_THRESH(4)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .WD(WD), .WEN(WEN), .RD(RD), .REN(REN),
        .RD_VALID(RD_VALID), .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL),
        .AEMPTY(AEMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW),
        .UNDERFLOW(UNDERFLOW), .ERR_CLR(ERR_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset;
        #12;
        total++; if (COUNT !== 6'd0) $display("FAIL reset_count got=%0d want=0", COUNT); else passed++;
        total++; if ({EMPTY, AEMPTY, FULL, AFULL} !== 4'b1100) $display("FAIL reset_flags got=%b want=1100", {EMPTY, AEMPTY, FULL, AFULL}); else passed++;
        total++; if (RD !== 16'h0000) $display("FAIL reset_rd got=%h want=0000", RD); else passed++;
        total++; if ({RD_VALID, OVERFLOW, UNDERFLOW} !== 3'b000) $display("FAIL reset_misc got=%b want=000", {RD_VALID, OVERFLOW, UNDERFLOW}); else passed++;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_fill;
        logic [5:0] c;
        for (int i = 0; i < 32; i++) begin
            WEN = 1'b1; WD = 16'(i);
            @(negedge CLK);
            c = 6'(i + 1);
            total++; if (COUNT !== c) $display("FAIL fill_count i=%0d got=%0d want=%0d", i, COUNT, c); else passed++;
            total++; if ({FULL, AFULL, EMPTY, AEMPTY} !== {c == 6'd32, c >= 6'd28, 1'b0, c <= 6'd4})
                $display("FAIL fill_flags i=%0d got=%b want=%b", i, {FULL, AFULL, EMPTY, AEMPTY}, {c == 6'd32, c >= 6'd28, 1'b0, c <= 6'd4});
            else passed++;
        end
        WEN = 1'b0;
    endtask

    task automatic test_overflow;
        WEN = 1'b1; WD = 16'hBEEF;
        @(negedge CLK);
        WEN = 1'b0;
        total++; if (OVERFLOW !== 1'b1) $display("FAIL ovf_set got=%b want=1", OVERFLOW); else passed++;
        total++; if (COUNT !== 6'd32 || FULL !== 1'b1) $display("FAIL ovf_count got=%0d/%b want=32/1", COUNT, FULL); else passed++;
        @(negedge CLK);
        total++; if (OVERFLOW !== 1'b1) $display("FAIL ovf_sticky got=%b want=1", OVERFLOW); else passed++;
    endtask

    task automatic test_drain;
        logic [5:0] c;
        for (int i = 0; i < 32; i++) begin
            REN = 1'b1;
            @(negedge CLK);
            c = 6'(31 - i);
            total++; if (RD !== 16'(i) || RD_VALID !== 1'b1) $display("FAIL drain_rd i=%0d got=%h/%b want=%h/1", i, RD, RD_VALID, 16'(i)); else passed++;
            total++; if (COUNT !== c || EMPTY !== (c == 6'd0) || AEMPTY !== (c <= 6'd4))
                $display("FAIL drain_flags i=%0d got=%0d/%b/%b want=%0d/%b/%b", i, COUNT, EMPTY, AEMPTY, c, c == 6'd0, c <= 6'd4);
            else passed++;
        end
        REN = 1'b0;
        @(negedge CLK);
        total++; if (RD_VALID !== 1'b0 || RD !== 16'h001F) $display("FAIL drain_hold got=%b/%h want=0/001f", RD_VALID, RD); else passed++;
        total++; if (OVERFLOW !== 1'b1) $display("FAIL drain_ovf_kept got=%b want=1", OVERFLOW); else passed++;
    endtask

    task automatic test_err_clr;
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        total++; if (OVERFLOW !== 1'b0) $display("FAIL errclr_ovf got=%b want=0", OVERFLOW); else passed++;
    endtask

    task automatic test_underflow;
        REN = 1'b1;
        @(negedge CLK);
        REN = 1'b0;
        total++; if (UNDERFLOW !== 1'b1) $display("FAIL udf_set got=%b want=1", UNDERFLOW); else passed++;
        total++; if (RD_VALID !== 1'b0 || RD !== 16'h001F) $display("FAIL udf_rd got=%b/%h want=0/001f", RD_VALID, RD); else passed++;
        total++; if (COUNT !== 6'd0 || EMPTY !== 1'b1) $display("FAIL udf_count got=%0d/%b want=0/1", COUNT, EMPTY); else passed++;
        REN = 1'b1; ERR_CLR = 1'b1;
        @(negedge CLK);
        REN = 1'b0;
        total++; if (UNDERFLOW !== 1'b1) $display("FAIL udf_set_wins got=%b want=1", UNDERFLOW); else passed++;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        total++; if (UNDERFLOW !== 1'b0) $display("FAIL udf_clear got=%b want=0", UNDERFLOW); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp;
        for (int i = 0; i < 10; i++) begin
            WEN = 1'b1; WD = 16'h0100 + 16'(i);
            @(negedge CLK);
        end
        WEN = 1'b0;
        total++; if (COUNT !== 6'd10) $display("FAIL b2b_preload got=%0d want=10", COUNT); else passed++;
        for (int k = 0; k < 100; k++) begin
            WEN = 1'b1; REN = 1'b1; WD = 16'h010A + 16'(k);
            @(negedge CLK);
            exp = 16'h0100 + 16'(k);
            total++; if (RD !== exp || RD_VALID !== 1'b1 || COUNT !== 6'd10)
                $display("FAIL b2b_stream k=%0d got=%h/%b/%0d want=%h/1/10", k, RD, RD_VALID, COUNT, exp);
            else passed++;
        end
        WEN = 1'b0; REN = 1'b0;
        for (int j = 0; j < 22; j++) begin
            WEN = 1'b1; WD = 16'h0200 + 16'(j);
            @(negedge CLK);
        end
        WEN = 1'b0;
        total++; if (FULL !== 1'b1 || COUNT !== 6'd32) $display("FAIL b2b_full got=%b/%0d want=1/32", FULL, COUNT); else passed++;
        WEN = 1'b1; REN = 1'b1; WD = 16'hDEAD;
        @(negedge CLK);
        WEN = 1'b0; REN = 1'b0;
        total++; if (RD !== 16'h0164 || RD_VALID !== 1'b1) $display("FAIL full_rw_rd got=%h/%b want=0164/1", RD, RD_VALID); else passed++;
        total++; if (COUNT !== 6'd31 || FULL !== 1'b0 || OVERFLOW !== 1'b1)
            $display("FAIL full_rw_state got=%0d/%b/%b want=31/0/1", COUNT, FULL, OVERFLOW);
        else passed++;
        for (int j = 0; j < 31; j++) begin
            REN = 1'b1;
            @(negedge CLK);
            exp = (j < 9) ? 16'h0165 + 16'(j) : 16'h0200 + 16'(j - 9);
            total++; if (RD !== exp) $display("FAIL full_rw_drain j=%0d got=%h want=%h", j, RD, exp); else passed++;
        end
        REN = 1'b0;
        total++; if (EMPTY !== 1'b1) $display("FAIL full_rw_empty got=%b want=1", EMPTY); else passed++;
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 17; i++) begin
            WEN = 1'b1; WD = 16'h0300 + 16'(i);
            @(negedge CLK);
        end
        WEN = 1'b0;
        total++; if (COUNT !== 6'd17) $display("FAIL rmid_pre got=%0d want=17", COUNT); else passed++;
        #2 RESET_N = 1'b0;
        #1;
        total++; if (COUNT !== 6'd0 || {EMPTY, AEMPTY, FULL, AFULL} !== 4'b1100)
            $display("FAIL rmid_async got=%0d/%b want=0/1100", COUNT, {EMPTY, AEMPTY, FULL, AFULL});
        else passed++;
        total++; if (RD !== 16'h0000 || RD_VALID !== 1'b0) $display("FAIL rmid_rd got=%h/%b want=0000/0", RD, RD_VALID); else passed++;
        @(negedge CLK);
        RESET_N = 1'b1;
        WEN = 1'b1; WD = 16'h00AA;
        @(negedge CLK);
        WEN = 1'b0; REN = 1'b1;
        @(negedge CLK);
        REN = 1'b0;
        total++; if (RD !== 16'h00AA || RD_VALID !== 1'b1) $display("FAIL rmid_first got=%h/%b want=00aa/1", RD, RD_VALID); else passed++;
        total++; if (COUNT !== 6'd0 || EMPTY !== 1'b1) $display("FAIL rmid_after got=%0d/%b want=0/1", COUNT, EMPTY); else passed++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_err_clr();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tpsram_fifo.md
Name: tpsram_fifo

Overview:
Parametrised synchronous FIFO built around an inferred two-port RAM, with one write port and one read port on a single clock. It is the next generation of the fixed 32x16 two-port SRAM wrapper: width and depth are generic, and it adds pointer management, full/empty and threshold flags, an occupancy count, and sticky error flags. It sits between DM command/data producers and consumers that previously drove the raw RAM addresses themselves.

Parameters:
DATA_WIDTH, 16, width of WD/RD in bits (1..36)
ADDR_WIDTH, 5, log2 of depth; DEPTH = 2**ADDR_WIDTH (2..10)
AFULL_THRESH, 28, AFULL asserts when COUNT >= this value (1..DEPTH)
AEMPTY_THRESH, 4, AEMPTY asserts when COUNT <= this value (0..DEPTH-1)

Ports:
CLK  in  1  single clock; all logic on the rising edge
RESET_N  in  1  asynchronous active-low reset
WD  in  DATA_WIDTH  write data
WEN  in  1  write request
RD  out  DATA_WIDTH  read data, registered
REN  in  1  read request
RD_VALID  out  1  one-cycle pulse: RD holds newly read word
FULL  out  1  COUNT == DEPTH
EMPTY  out  1  COUNT == 0
AFULL  out  1  COUNT >= AFULL_THRESH
AEMPTY  out  1  COUNT <= AEMPTY_THRESH
COUNT  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
OVERFLOW  out  1  sticky: write attempted while FULL
UNDERFLOW  out  1  sticky: read attempted while EMPTY
ERR_CLR  in  1  clears OVERFLOW/UNDERFLOW

Behaviour:
- Reset (async assert, sync release): write/read pointers = 0, COUNT = 0, EMPTY = 1, AEMPTY = 1, FULL = 0, AFULL = 0, RD = 0, RD_VALID = 0, OVERFLOW = 0, UNDERFLOW = 0. RAM contents are not reset. Reset mid-operation discards all stored data immediately.
- Pointers: ADDR_WIDTH+1 bits; low ADDR_WIDTH bits address the RAM, MSB is wrap bit. Increment by 1 modulo 2**(ADDR_WIDTH+1).
- Write accepted = WEN & ~FULL: WD stored at write pointer, write pointer increments.
- Read accepted = REN & ~EMPTY: word at read pointer loaded into RD on the same edge (RD valid the cycle after REN is sampled, i.e. 1-cycle latency); RD_VALID = 1 for exactly that cycle; read pointer increments.
- RD holds its last value when no read is accepted, including during underflow.
- Acceptance uses flags as they stand at the start of the cycle: write with FULL is refused even if a read is accepted in the same cycle; read with EMPTY is refused even if a write is accepted in the same cycle (no write-through).
- COUNT: +1 on write only, -1 on read only, unchanged on both or neither. FULL/EMPTY/AFULL/AEMPTY are registered and consistent with COUNT in the same cycle.
- Simultaneous read and write at non-boundary occupancy: both accepted, COUNT unchanged, order preserved.
- OVERFLOW set on WEN & FULL; UNDERFLOW set on REN & EMPTY. ERR_CLR clears both on the next edge; if a set condition and ERR_CLR coincide, set wins.
- Refused operations change no pointer, COUNT, or RAM content.
- RAM: two-port, synchronous write and read, no read-during-write collision possible (EMPTY blocks reading an unwritten entry).

Test Plan:
- Fill: 32 writes of 0x0000..0x001F, no reads -> COUNT steps to 32; AFULL rises at COUNT=28; FULL rises after 32nd write; EMPTY falls after the first write.
- Overflow: with FULL=1, WEN=1 with WD=0xBEEF -> OVERFLOW=1, COUNT stays 32; subsequent drain returns no 0xBEEF; ERR_CLR pulse -> OVERFLOW=0.
- Drain: 32 back-to-back REN -> RD = 0x0000..0x001F in order, each one cycle after its REN, RD_VALID high 32 cycles; EMPTY=1 after last read, AEMPTY rises at COUNT=4.
- Underflow: REN while EMPTY -> UNDERFLOW=1, RD_VALID=0, RD keeps 0x001F; ERR_CLR and REN&EMPTY in same cycle -> UNDERFLOW stays 1.
- Concurrent/wrap: preload 10 words, then 100 cycles of WEN&REN with incrementing data -> COUNT stays 10, output sequence exact, pointers wrap repeatedly; at FULL with WEN&REN, read accepted, write refused, COUNT=31.
- Reset mid-burst: assert RESET_N=0 asynchronously between edges at COUNT=17 -> all outputs reach reset values without a clock edge; after release, write 0x00AA and read it back as first word.
